// File: rtl/mem_hub_pkg.sv
// mem_hub_pkg: shared length encodings, fsm states, counter width and helpers for mem_hub
package mem_hub_pkg;
  localparam logic [1:0] LEN_B = 2'd0;
  localparam logic [1:0] LEN_H = 2'd1;
  localparam logic [1:0] LEN_W = 2'd2;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic logic [31:0] len_mask(input logic [1:0] len);
    return len == LEN_B ? 32'h0000_00ff : len == LEN_H ? 32'h0000_ffff : 32'hffff_ffff;
  endfunction
endpackage

// File: rtl/mem_hub_arb.sv
// mem_hub_arb: combinational fixed-priority/round-robin arbiter (pend, last_g in; one-hot grant, gidx, valid out)
module mem_hub_arb
  import mem_hub_pkg::*;
#(
  parameter int N_CH = 2,
  parameter int RR_MODE = 0,
  localparam int IDX_W = idx_w(N_CH)
) (
  input  logic [N_CH-1:0]  pend,
  input  logic [IDX_W-1:0] last_g,
  output logic [N_CH-1:0]  grant,
  output logic [IDX_W-1:0] gidx,
  output logic             valid
);
  always_comb begin
    int idx;
    gidx = '0;
    valid = 1'b0;
    idx = 0;
    for (int k = 0; k < N_CH; k++) begin
      idx = RR_MODE != 0 ? (int'(last_g) + 1 + k) % N_CH : k;
      if (!valid && pend[idx[IDX_W-1:0]]) begin
        gidx = idx[IDX_W-1:0];
        valid = 1'b1;
      end
    end
  end
  assign grant = valid ? N_CH'(1) << gidx : '0;
endmodule

// File: rtl/mem_hub.sv
// mem_hub: arbitrates N_CH channel read/write requests (ch_*) onto one core memory port (core_*/co_*), ack + shared ch_dout back
module mem_hub
  import mem_hub_pkg::*;
#(
  parameter int MADDR_L = 32,
  parameter int DATA_L = 32,
  parameter int N_CH = 2,
  parameter int RR_MODE = 0,
  parameter int MEM_LAT = 1,
  localparam int IDX_W = idx_w(N_CH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CH-1:0]           ch_re,
  input  logic [N_CH-1:0]           ch_we,
  input  logic [2*N_CH-1:0]         ch_rlen,
  input  logic [2*N_CH-1:0]         ch_wlen,
  input  logic [MADDR_L*N_CH-1:0]   ch_raddr,
  input  logic [MADDR_L*N_CH-1:0]   ch_waddr,
  input  logic [DATA_L*N_CH-1:0]    ch_din,
  output logic [N_CH-1:0]           ch_ack,
  output logic [DATA_L-1:0]         ch_dout,
  output logic                      hub_busy,
  input  logic [DATA_L-1:0]         core_din,
  output logic [DATA_L-1:0]         core_dout,
  output logic [MADDR_L-1:0]        core_raddr,
  output logic [MADDR_L-1:0]        core_waddr,
  output logic                      co_re,
  output logic                      co_we,
  output logic [1:0]                co_rlen,
  output logic [1:0]                co_wlen
);
  state_t state, nxt;
  logic [N_CH-1:0] grant, l_gnt;
  logic [IDX_W-1:0] gidx, last_g;
  logic valid, l_re, s_re, s_we;
  logic [1:0] l_rlen, s_rlen, s_wlen;
  logic [CNT_W-1:0] cnt;
  logic [MADDR_L-1:0] s_raddr, s_waddr;
  logic [DATA_L-1:0] s_din;
  mem_hub_arb #(.N_CH(N_CH), .RR_MODE(RR_MODE)) u_arb (
    .pend(ch_re | ch_we),
    .last_g(last_g),
    .grant(grant),
    .gidx(gidx),
    .valid(valid)
  );
  assign s_re = ch_re[gidx];
  assign s_we = ch_we[gidx];
  assign s_rlen = ch_rlen[2*gidx +: 2];
  assign s_wlen = ch_wlen[2*gidx +: 2];
  assign s_raddr = ch_raddr[MADDR_L*gidx +: MADDR_L];
  assign s_waddr = ch_waddr[MADDR_L*gidx +: MADDR_L];
  assign s_din = ch_din[DATA_L*gidx +: DATA_L];
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= S_IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  nxt = valid ? S_ISSUE : S_IDLE;
      S_ISSUE: nxt = S_WAIT;
      S_WAIT:  nxt = cnt == CNT_W'(1) ? S_DONE : S_WAIT;
      default: nxt = S_IDLE;
    endcase
  end
  // strobes and fields default to zero so they are only non-zero during ISSUE
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      l_gnt <= '0;
      last_g <= IDX_W'(N_CH - 1);
      l_re <= 1'b0;
      l_rlen <= '0;
      cnt <= '0;
      ch_ack <= '0;
      ch_dout <= '0;
      hub_busy <= 1'b0;
      co_re <= 1'b0;
      co_we <= 1'b0;
      co_rlen <= '0;
      co_wlen <= '0;
      core_raddr <= '0;
      core_waddr <= '0;
      core_dout <= '0;
    end else begin
      ch_ack <= '0;
      co_re <= 1'b0;
      co_we <= 1'b0;
      co_rlen <= '0;
      co_wlen <= '0;
      core_raddr <= '0;
      core_waddr <= '0;
      core_dout <= '0;
      hub_busy <= nxt != S_IDLE;
      case (state)
        S_IDLE: if (valid) begin
          l_gnt <= grant;
          last_g <= gidx;
          l_re <= s_re;
          l_rlen <= s_rlen;
          co_re <= s_re;
          co_we <= s_we;
          co_rlen <= s_re ? s_rlen : 2'd0;
          co_wlen <= s_we ? s_wlen : 2'd0;
          core_raddr <= s_re ? s_raddr : '0;
          core_waddr <= s_we ? s_waddr : '0;
          core_dout <= s_we ? s_din : '0;
        end
        S_ISSUE: cnt <= CNT_W'(MEM_LAT);
        S_WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            ch_ack <= l_gnt;
            if (l_re) ch_dout <= core_din & DATA_L'(len_mask(l_rlen));
          end
        end
        default: ;
      endcase
    end
endmodule

// File: doc/mem_hub.md
# mem_hub

Parametrised memory hub arbitrating N_CH requester channels (instruction fetch, memory access, future DMA/debug) onto the single core memory port (core_din/core_dout/core_raddr/core_waddr/co_re/co_we/co_rlen/co_wlen). It generalises the two-channel mh_* hookup to a configurable channel count with fixed-priority or round-robin arbitration, configurable memory read latency and length-masked read data. It sits between the pipeline stages and the memory port inside cpu_core.

## Interface
- MADDR_L, 32, address width
- DATA_L, 32, data width (multiple of 8, ≥32)
- N_CH, 2, requester channels (1..8)
- RR_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin
- MEM_LAT, 1, cycles from issue cycle to core_din valid (1..15)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- ch_re  in  N_CH  per-channel read request, level, held until ack
- ch_we  in  N_CH  per-channel write request, level, held until ack
- ch_rlen  in  2*N_CH  read length per channel, slice [2i+1:2i]
- ch_wlen  in  2*N_CH  write length per channel
- ch_raddr  in  MADDR_L*N_CH  read address per channel
- ch_waddr  in  MADDR_L*N_CH  write address per channel
- ch_din  in  DATA_L*N_CH  write data per channel
- ch_ack  out  N_CH  one-hot completion pulse
- ch_dout  out  DATA_L  read data of last completed read, shared bus
- hub_busy  out  1  transaction in flight (state ≠ IDLE)
- core_din  in  DATA_L  memory read data
- core_dout  out  DATA_L  memory write data
- core_raddr, core_waddr  out  MADDR_L  memory addresses
- co_re, co_we  out  1  memory read/write strobes
- co_rlen, co_wlen  out  2  length: 0 = 1 byte, 1 = 2 bytes, 2/3 = 4 bytes

## Operation
- Request of channel i pending = ch_re[i] | ch_we[i]; sampled only in IDLE.
- FSM: IDLE → ISSUE → WAIT → DONE → IDLE.
  - IDLE: if any pending, pick grant g, latch g and its re/we/rlen/wlen/addresses/din; → ISSUE. Else stay.
  - ISSUE: co_re/co_we asserted for exactly this cycle with latched fields; load counter with MEM_LAT; → WAIT.
  - WAIT: counter decrements each cycle; at counter = 1 capture core_din (if latched re) into ch_dout after masking; → DONE.
  - DONE: ch_ack[g] = 1 for this cycle only; requests ignored; → IDLE.
- Simultaneous re and we on one channel: single transaction, both strobes in the same ISSUE cycle, one ack.
- Read masking: rlen 0 keeps [7:0], 1 keeps [15:0], 2/3 keeps [31:0]; upper bits zero. Sign extension is the requester's job.
- Write-only transaction: ch_dout unchanged.
- Fixed mode: lowest pending index wins. Round-robin: search starts at last_g+1 mod N_CH; last_g updates on each grant.
- Requester must drop its request no later than the IDLE cycle after ack; a request still high there is a new transaction.

## Timing
- Issue cycle t = arbitration cycle + 1; core_din sampled at end of cycle t+MEM_LAT; ack in cycle t+MEM_LAT+1. Transaction occupancy MEM_LAT+3 cycles.
- All outputs registered. Reset values: ch_ack 0, ch_dout 0, hub_busy 0, co_re/co_we 0, co_rlen/co_wlen 0, core_dout/core_raddr/core_waddr 0; state IDLE, last_g = N_CH-1 (channel 0 first).
- Reset mid-transaction: immediate return to reset values; in-flight response dropped, no ack issued.
- Strobes, addresses and data are 0 outside ISSUE.

## Structure
- Shared package: length encodings (LEN_B/LEN_H/LEN_W), FSM state encoding, counter width constant.
- One sub-module: mem_hub_arb (pending vector, last_g, mode → one-hot grant plus index), combinational.

## Test plan
- Single read, N_CH=2, MEM_LAT=1: ch_re[0], raddr 0x100, rlen 2, core_din 0xDEADBEEF → co_re in cycle 1, ch_ack[0] in cycle 3, ch_dout 0xDEADBEEF.
- Length masking: rlen 0 then 1 with core_din 0xDEADBEEF → ch_dout 0x000000EF, then 0x0000BEEF.
- Contention, RR_MODE=0 vs 1, both channels held for 4 transactions → fixed: grants 0,0,0,0; round-robin: 0,1,0,1.
- MEM_LAT=3, ch_we[1] addr 0x20 din 0x55 wlen 0 → co_we one cycle with waddr 0x20, dout 0x55, wlen 0; ack[1] 4 cycles after issue; ch_dout unchanged.
- Combined re+we on channel 0 → co_re and co_we in the same cycle, exactly one ack.
- rst to 0 during WAIT → all outputs 0 immediately, no ack; after release, held request re-granted from IDLE.
